// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the execute-stage multiply/divide unit.
// The signed-fix helper is only referenced when MDU_SIGNED_EN is defined.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5,
    OpMfhi  = 3'd6,
    OpMflo  = 3'd7
  } mdu_op_e;

  typedef enum logic {StIdle, StBusy} mdu_state_e;

  // Wide enough for a 2*WIDTH product with WIDTH up to 64.
  localparam int unsigned FixW = 128;

  // Two's-complement negate when neg is set; callers keep the low bits they need.
  function automatic logic [FixW-1:0] sign_fix(input logic [FixW-1:0] v, input logic neg);
    return neg ? (~v + 128'd1) : v;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: the lowest set select bit (youngest source) wins,
// otherwise the register-file value passes through.
module fwd_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NFWD  = 2
) (
  input  logic [WIDTH-1:0]      reg_i,
  input  logic [NFWD*WIDTH-1:0] fwd_i,
  input  logic [NFWD-1:0]       sel_i,
  output logic [WIDTH-1:0]      data_o
);

  always_comb begin
    data_o = reg_i;
    // Walk from oldest to youngest so the lowest index is applied last.
    for (int k = int'(NFWD) - 1; k >= 0; k--) begin
      if (sel_i[k]) data_o = fwd_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/malu_mdu.sv
// EX-stage multiply/divide unit: forwarded operands, radix-2 iterative engine, HI/LO.
// Define MDU_SIGNED_EN to give MULT/DIV two's-complement semantics.
module malu_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NFWD  = 2,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic                  in_CLK,
  input  logic                  in_RST,
  input  logic                  in_start,
  input  logic [2:0]            in_op,
  input  logic [WIDTH-1:0]      in_A,
  input  logic [WIDTH-1:0]      in_B,
  input  logic [NFWD*WIDTH-1:0] in_FWD,
  input  logic [NFWD-1:0]       in_FWDX,
  input  logic [NFWD-1:0]       in_FWDY,
  output logic [WIDTH-1:0]      out_R,
  output logic [WIDTH-1:0]      out_HI,
  output logic [WIDTH-1:0]      out_LO,
  output logic                  out_lock,
  output logic                  out_done,
  output logic                  out_divzero
);

  logic [WIDTH-1:0] x, y, xm, ym;
  mdu_op_e          op;
  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d, wrk_q, wrk_d, opd_q, opd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d, dz_q, dz_d, done_q, done_d, dvz_q, dvz_d;
  logic [WIDTH:0]   hi_s, sh, trial;
  logic [WIDTH-1:0] acc_n, wrk_n, hi_fin, lo_fin;

  assign op = mdu_op_e'(in_op);

  fwd_mux #(.WIDTH(WIDTH), .NFWD(NFWD)) u_fwd_x (
    .reg_i  (in_A),
    .fwd_i  (in_FWD),
    .sel_i  (in_FWDX),
    .data_o (x)
  );

  fwd_mux #(.WIDTH(WIDTH), .NFWD(NFWD)) u_fwd_y (
    .reg_i  (in_B),
    .fwd_i  (in_FWD),
    .sel_i  (in_FWDY),
    .data_o (y)
  );

`ifdef MDU_SIGNED_EN
  logic             sgn_op;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [FixW-1:0]  prod_fix, q_fix, r_fix;

  assign sgn_op = (op == OpMult) || (op == OpDiv);
  assign xm = (sgn_op && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  assign ym = (sgn_op && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;
`else
  assign xm = x;
  assign ym = y;
`endif

  // One radix-2 step: acc/wrk hold {HI,LO} of the product or {remainder,dividend/quotient}.
  always_comb begin
    hi_s  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    sh    = {acc_q, wrk_q[WIDTH-1]};
    trial = sh - {1'b0, opd_q};
    if (div_q) begin
      acc_n = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
      wrk_n = {wrk_q[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      acc_n = hi_s[WIDTH:1];
      wrk_n = {hi_s[0], wrk_q[WIDTH-1:1]};
    end
  end

`ifdef MDU_SIGNED_EN
  // A zero divisor keeps the all-ones quotient; remainder re-signing restores the dividend.
  always_comb begin
    prod_fix = sign_fix(FixW'({acc_n, wrk_n}), negq_q);
    q_fix    = sign_fix(FixW'(wrk_n), negq_q && !dz_q);
    r_fix    = sign_fix(FixW'(acc_n), negr_q);
    hi_fin   = div_q ? r_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    lo_fin   = div_q ? q_fix[WIDTH-1:0] : prod_fix[WIDTH-1:0];
  end
`else
  assign hi_fin = acc_n;
  assign lo_fin = wrk_n;
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    wrk_d   = wrk_q;
    opd_d   = opd_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dvz_d   = 1'b0;
    out_R   = '0;
`ifdef MDU_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_start) begin
          unique case (op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              div_d   = in_op[1];
              acc_d   = '0;
              wrk_d   = in_op[1] ? xm : ym;
              opd_d   = in_op[1] ? ym : xm;
              dz_d    = in_op[1] && (y == '0);
              cnt_d   = CW'(WIDTH - 1);
              state_d = StBusy;
`ifdef MDU_SIGNED_EN
              negq_d  = sgn_op && (x[WIDTH-1] ^ y[WIDTH-1]);
              negr_d  = sgn_op && in_op[1] && x[WIDTH-1];
`endif
            end
            OpMthi: hi_d  = x;
            OpMtlo: lo_d  = x;
            OpMfhi: out_R = hi_q;
            OpMflo: out_R = lo_q;
            default: ;
          endcase
        end
      end
      StBusy: begin
        acc_d = acc_n;
        wrk_d = wrk_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          hi_d    = hi_fin;
          lo_d    = lo_fin;
          done_d  = 1'b1;
          dvz_d   = dz_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      wrk_q   <= '0;
      opd_q   <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dvz_q   <= 1'b0;
`ifdef MDU_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      opd_q   <= opd_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dvz_q   <= dvz_d;
`ifdef MDU_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign out_HI      = hi_q;
  assign out_LO      = lo_q;
  assign out_lock    = (state_q == StBusy) && in_start;
  assign out_done    = done_q;
  assign out_divzero = dvz_q;

endmodule

// File: tb/tb_malu_mdu.sv
// Directed bench for malu_mdu with a scoreboard of expected HI/LO results.
module tb_malu_mdu;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NFWD  = 2;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, MFHI = 3'd6, MFLO = 3'd7;

  logic                  in_CLK = 1'b0;
  logic                  in_RST, in_start;
  logic [2:0]            in_op;
  logic [WIDTH-1:0]      in_A, in_B;
  logic [NFWD*WIDTH-1:0] in_FWD;
  logic [NFWD-1:0]       in_FWDX, in_FWDY;
  logic [WIDTH-1:0]      out_R, out_HI, out_LO;
  logic                  out_lock, out_done, out_divzero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  always #5 in_CLK = ~in_CLK;

  malu_mdu #(.WIDTH(WIDTH), .NFWD(NFWD)) dut (
    .in_CLK      (in_CLK),
    .in_RST      (in_RST),
    .in_start    (in_start),
    .in_op       (in_op),
    .in_A        (in_A),
    .in_B        (in_B),
    .in_FWD      (in_FWD),
    .in_FWDX     (in_FWDX),
    .in_FWDY     (in_FWDY),
    .out_R       (out_R),
    .out_HI      (out_HI),
    .out_LO      (out_LO),
    .out_lock    (out_lock),
    .out_done    (out_done),
    .out_divzero (out_divzero)
  );

  task automatic step();
    @(posedge in_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model of one mul/div, using the operands after forwarding.
  task automatic push(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    int          sx, sy;
    e.dz = 1'b0;
    sx = x;
    sy = y;
`ifdef MDU_SIGNED_EN
    if (op == MULT) begin
      p = 64'(longint'(sx) * longint'(sy));
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (op == DIV) begin
      if (y == 0) begin
        e.lo = '1; e.hi = x; e.dz = 1'b1;
      end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000; e.hi = 0;
      end else begin
        e.lo = 32'(sx / sy); e.hi = 32'(sx % sy);
      end
    end else
`endif
    if (op == MULT || op == MULTU) begin
      p = 64'(x) * 64'(y);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == 0) begin
      e.lo = '1; e.hi = x; e.dz = 1'b1;
    end else begin
      e.lo = x / y; e.hi = x % y;
    end
    sb.push_back(e);
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_hi"}, 64'(out_HI), 64'(e.hi));
    chk({tag, "_lo"}, 64'(out_LO), 64'(e.lo));
    chk({tag, "_dz"}, 64'(out_divzero), 64'(e.dz));
  endtask

  // Issue a mul/div, wait (bounded) for out_done and check latency and result.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] fx, input logic [1:0] fy,
                        input logic [31:0] f0, input logic [31:0] f1,
                        input logic [31:0] ex, input logic [31:0] ey);
    int n;
    in_op = op; in_A = a; in_B = b; in_FWDX = fx; in_FWDY = fy; in_FWD = {f1, f0};
    in_start = 1'b1;
    push(op, ex, ey);
    step();
    in_start = 1'b0;
    n = 0;
    while (!out_done && n < int'(WIDTH) + 8) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(WIDTH));
    compare_pop(tag);
  endtask

  initial begin
    int n, seen;
    in_RST = 1'b1; in_start = 1'b0; in_op = MFLO; in_A = '0; in_B = '0;
    in_FWD = '0; in_FWDX = '0; in_FWDY = '0;
    repeat (3) step();
    in_RST = 1'b0;
    #1;
    chk("rst_hi", 64'(out_HI), 64'd0);
    chk("rst_lo", 64'(out_LO), 64'd0);
    chk("rst_done", 64'(out_done), 64'd0);
    chk("rst_dz", 64'(out_divzero), 64'd0);
    chk("rst_lock", 64'(out_lock), 64'd0);

    run_md("multu_max", MULTU, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b00, 32'd3, 32'd4,
           32'hFFFF_FFFF, 32'd2);
    step();
    chk("done_pulse_width", 64'(out_done), 64'd0);

    run_md("divu_fwd", DIVU, 32'd55, 32'd999, 2'b10, 2'b01, 32'd7, 32'd100, 32'd100, 32'd7);
    run_md("divu_zero", DIVU, 32'h1234, 32'd0, 2'b00, 2'b00, 32'd1, 32'd1, 32'h1234, 32'd0);

    // MFLO re-presented every cycle while the multiply runs.
    in_op = MULTU; in_A = 32'h0001_0000; in_B = 32'h30; in_FWDX = '0; in_FWDY = '0;
    in_start = 1'b1;
    push(MULTU, 32'h0001_0000, 32'h30);
    step();
    in_op = MFLO;
    #1;
    n = 0;
    while (out_lock && n < int'(WIDTH) + 8) begin
      n++;
      step();
    end
    chk("mflo_lock_cycles", 64'(n), 64'(WIDTH));
    chk("mflo_done", 64'(out_done), 64'd1);
    chk("mflo_out_r", 64'(out_R), 64'h0030_0000);
    compare_pop("mflo_stall");
    in_start = 1'b0;

    // Lowest forwarding index wins when both selects are set.
    in_op = MTLO; in_A = 32'd77; in_FWD = {32'd9, 32'd5}; in_FWDX = 2'b11; in_start = 1'b1;
    step();
    chk("mtlo_fwd_lowest", 64'(out_LO), 64'd5);
    in_op = MTHI; in_A = 32'h0000_ABCD; in_FWDX = 2'b00;
    step();
    chk("mthi_reg", 64'(out_HI), 64'h0000_ABCD);
    in_op = MFHI;
    #1;
    chk("mfhi_out_r", 64'(out_R), 64'h0000_ABCD);
    in_op = MTLO;
    #1;
    chk("mtlo_out_r_zero", 64'(out_R), 64'd0);
    in_start = 1'b0;

    // Reset mid-divide, with a new op offered alongside reset.
    in_op = DIVU; in_A = 32'd1000; in_B = 32'd3; in_start = 1'b1;
    step();
    in_start = 1'b0;
    repeat (10) step();
    in_RST = 1'b1; in_start = 1'b1; in_op = DIVU;
    step();
    in_RST = 1'b0; in_op = MFLO;
    #1;
    chk("rst_mid_lock", 64'(out_lock), 64'd0);
    chk("rst_mid_hi", 64'(out_HI), 64'd0);
    chk("rst_mid_lo", 64'(out_LO), 64'd0);
    chk("rst_mid_out_r", 64'(out_R), 64'd0);
    in_start = 1'b0;
    seen = 0;
    repeat (WIDTH + 4) begin
      step();
      if (out_done) seen++;
    end
    chk("rst_mid_no_done", 64'(seen), 64'd0);

    run_md("mult_neg", MULT, 32'hFFFF_FFFD, 32'd4, 2'b00, 2'b00, 32'd0, 32'd0,
           32'hFFFF_FFFD, 32'd4);
    run_md("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 32'd0, 32'd0,
           32'hFFFF_FFF9, 32'd2);
    run_md("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 32'd0, 32'd0,
           32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div_neg_zero", DIV, 32'hFFFF_FF00, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0,
           32'hFFFF_FF00, 32'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
